// File: rtl/bus_sigs_seq_if.sv
// Bundles the sequencer's control inputs, the downstream operand/result bus
// and the status/signature outputs.
interface bus_sigs_seq_if;
    logic       start;
    logic       step_en;
    logic       abort;
    logic [3:0] result;
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       sel;
    logic       busy;
    logic       done;
    logic [7:0] sig;

    modport master (
        output start, step_en, abort, result,
        input  op_a, op_b, sel, busy, done, sig
    );

    modport slave (
        input  start, step_en, abort, result,
        output op_a, op_b, sel, busy, done, sig
    );
endinterface

// File: rtl/bus_sigs_seq.sv
// Operand sweep sequencer for a downstream bus_sigs stage: walks op_a/op_b over
// 0..A_LAST x 0..B_LAST. Macro BUS_SIGS_SEQ_SIG_EN enables the result signature.
module bus_sigs_seq #(
    parameter int unsigned A_LAST = 3,
    parameter int unsigned B_LAST = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    bus_sigs_seq_if.slave  bus
);

    localparam logic [3:0] A_LAST_C = 4'(A_LAST);
    localparam logic [3:0] B_LAST_C = 4'(B_LAST);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [3:0] op_a_r;
    logic [3:0] op_b_r;
    logic [3:0] op_a_s;
    logic [3:0] op_b_s;
    logic       sel_r;
    logic       busy_r;
    logic       done_r;
    logic       step_s;
    logic       launch_s;

    // Next-state and operand sequencing; abort outranks stepping and the final step.
    always_comb begin
        state_s  = state_r;
        op_a_s   = op_a_r;
        op_b_s   = op_b_r;
        step_s   = 1'b0;
        launch_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                op_a_s = 4'd0;
                op_b_s = 4'd0;
                if (bus.start && !bus.abort) begin
                    state_s  = ST_RUN;
                    launch_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    state_s = ST_IDLE;
                    op_a_s  = 4'd0;
                    op_b_s  = 4'd0;
                end else if (bus.step_en) begin
                    step_s = 1'b1;
                    if (op_a_r == A_LAST_C) begin
                        if (op_b_r == B_LAST_C) begin
                            state_s = ST_DONE;
                        end else begin
                            op_a_s = 4'd0;
                            op_b_s = op_b_r + 4'd1;
                        end
                    end else begin
                        op_a_s = op_a_r + 4'd1;
                    end
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                op_a_s  = 4'd0;
                op_b_s  = 4'd0;
            end
            default: begin
                state_s = ST_IDLE;
                op_a_s  = 4'd0;
                op_b_s  = 4'd0;
            end
        endcase
    end

    // State, operands and status flags, all registered from the next-state view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            op_a_r  <= 4'd0;
            op_b_r  <= 4'd0;
            sel_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            op_a_r  <= op_a_s;
            op_b_r  <= op_b_s;
            sel_r   <= (state_s == ST_RUN) && (op_b_s != 4'd0);
            busy_r  <= (state_s == ST_RUN);
            done_r  <= (state_s == ST_DONE);
        end
    end

    assign bus.op_a = op_a_r;
    assign bus.op_b = op_b_r;
    assign bus.sel  = sel_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

`ifdef BUS_SIGS_SEQ_SIG_EN
    logic [7:0] sig_r;

    function automatic logic [7:0] sig_fold(input logic [7:0] s, input logic [3:0] r);
        return {s[6:0], s[7]} ^ {4'h0, r};
    endfunction

    // Signature: cleared on launch, folded only on counted steps, held otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= 8'h00;
        end else if (launch_s) begin
            sig_r <= 8'h00;
        end else if (step_s) begin
            sig_r <= sig_fold(sig_r, bus.result);
        end else begin
            sig_r <= sig_r;
        end
    end

    assign bus.sig = sig_r;
`else
    assign bus.sig = 8'h00;
`endif

endmodule

// File: tb/tb_bus_sigs_seq.sv
// Directed self-checking bench for bus_sigs_seq: default 4x4 sweep, stalls,
// abort, busy-time start pulses, async reset, and 2x2 / 1x1 sweeps.
module tb_bus_sigs_seq;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;
    logic [7:0] exp_sig;

    bus_sigs_seq_if u_if ();
    bus_sigs_seq_if u_if1 ();
    bus_sigs_seq_if u_if0 ();

    bus_sigs_seq #(.A_LAST(3), .B_LAST(3)) u_dut (.clk(clk), .rst_n(rst_n), .bus(u_if.slave));
    bus_sigs_seq #(.A_LAST(1), .B_LAST(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(u_if1.slave));
    bus_sigs_seq #(.A_LAST(0), .B_LAST(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(u_if0.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] fold(input logic [7:0] s, input logic [3:0] r);
        return {s[6:0], s[7]} ^ {4'h0, r};
    endfunction

    function automatic logic [7:0] sig_exp(input logic [7:0] s);
`ifdef BUS_SIGS_SEQ_SIG_EN
        return s;
`else
        return 8'h00;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_busy"}, {7'd0, u_if.busy}, 8'h00);
        check_val({tag, "_done"}, {7'd0, u_if.done}, 8'h00);
        check_val({tag, "_op_a"}, {4'd0, u_if.op_a}, 8'h00);
        check_val({tag, "_op_b"}, {4'd0, u_if.op_b}, 8'h00);
        check_val({tag, "_sel"}, {7'd0, u_if.sel}, 8'h00);
    endtask

    // Full 4x4 sweep, optional stall of hold_len cycles at step hold_at,
    // optional start pokes while busy.
    task automatic sweep(input int hold_at, input int hold_len, input bit poke);
        int runs;
        int reps;
        runs = 0;
        u_if.step_en = 1'b1;
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        exp_sig = 8'h00;
        for (int i = 0; i < 16; i++) begin
            reps = (i == hold_at) ? hold_len + 1 : 1;
            for (int k = 0; k < reps; k++) begin
                u_if.step_en = (k == reps - 1) ? 1'b1 : 1'b0;
                u_if.result = 4'(i * 3 + 1 + k * 5);
                u_if.start = poke && ((i % 5) == 2);
                check_val("sw_op_a", {4'd0, u_if.op_a}, 8'(i % 4));
                check_val("sw_op_b", {4'd0, u_if.op_b}, 8'(i / 4));
                check_val("sw_sel", {7'd0, u_if.sel}, (i >= 4) ? 8'h01 : 8'h00);
                check_val("sw_busy", {7'd0, u_if.busy}, 8'h01);
                check_val("sw_done", {7'd0, u_if.done}, 8'h00);
                check_val("sw_sig", u_if.sig, sig_exp(exp_sig));
                if (u_if.busy) runs++;
                tick();
                if (u_if.step_en) exp_sig = fold(exp_sig, u_if.result);
            end
        end
        u_if.start = 1'b0;
        u_if.step_en = 1'b1;
        check_val("end_done", {7'd0, u_if.done}, 8'h01);
        check_val("end_busy", {7'd0, u_if.busy}, 8'h00);
        check_val("end_op_a", {4'd0, u_if.op_a}, 8'h03);
        check_val("end_op_b", {4'd0, u_if.op_b}, 8'h03);
        check_val("end_sig", u_if.sig, sig_exp(exp_sig));
        check_val("run_len", 8'(runs), 8'(16 + hold_len));
        for (int j = 0; j < 3; j++) begin
            tick();
            check_idle("post");
        end
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        exp_sig = 8'h00;
        rst_n = 1'b0;
        u_if.start = 1'b0;  u_if.step_en = 1'b1; u_if.abort = 1'b0; u_if.result = 4'h0;
        u_if1.start = 1'b0; u_if1.step_en = 1'b1; u_if1.abort = 1'b0; u_if1.result = 4'h1;
        u_if0.start = 1'b0; u_if0.step_en = 1'b1; u_if0.abort = 1'b0; u_if0.result = 4'h1;
        #12;
        check_idle("rst");
        check_val("rst_sig", u_if.sig, 8'h00);
        rst_n = 1'b1;
        tick();
        tick();
        check_idle("idle");

        sweep(-1, 0, 1'b0);
        sweep(6, 3, 1'b0);
        sweep(-1, 0, 1'b1);

        // Abort at op_a=1, op_b=2 with a simultaneous start.
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        exp_sig = 8'h00;
        for (int i = 0; i < 9; i++) begin
            u_if.result = 4'(i + 7);
            tick();
            exp_sig = fold(exp_sig, u_if.result);
        end
        check_val("ab_pre_a", {4'd0, u_if.op_a}, 8'h01);
        check_val("ab_pre_b", {4'd0, u_if.op_b}, 8'h02);
        u_if.abort = 1'b1;
        u_if.start = 1'b1;
        u_if.result = 4'hf;
        tick();
        u_if.start = 1'b0;
        u_if.abort = 1'b0;
        check_idle("ab");
        check_val("ab_sig", u_if.sig, sig_exp(exp_sig));
        for (int j = 0; j < 3; j++) begin
            tick();
            check_idle("ab_after");
        end
        u_if.abort = 1'b1;
        u_if.start = 1'b1;
        tick();
        u_if.abort = 1'b0;
        u_if.start = 1'b0;
        check_idle("ab_idle");
        tick();
        check_idle("ab_idle2");

        // Asynchronous reset between edges mid-sweep.
        u_if.start = 1'b1;
        tick();
        u_if.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            u_if.result = 4'(i + 2);
            tick();
        end
        check_val("rs_pre_busy", {7'd0, u_if.busy}, 8'h01);
        #3;
        rst_n = 1'b0;
        #1;
        check_idle("rs_async");
        check_val("rs_sig", u_if.sig, 8'h00);
        #2;
        rst_n = 1'b1;
        for (int j = 0; j < 4; j++) begin
            tick();
            check_idle("rs_after");
        end
        sweep(-1, 0, 1'b0);

        // 2x2 sweep with result tied to 1, and a 1x1 sweep.
        u_if1.start = 1'b1;
        u_if0.start = 1'b1;
        tick();
        u_if1.start = 1'b0;
        u_if0.start = 1'b0;
        check_val("s0_busy", {7'd0, u_if0.busy}, 8'h01);
        check_val("s0_done", {7'd0, u_if0.done}, 8'h00);
        begin
            logic [7:0] sig_tab [4];
            logic [3:0] a_tab [4];
            logic [3:0] b_tab [4];
            sig_tab = '{8'h00, 8'h01, 8'h03, 8'h07};
            a_tab = '{4'd0, 4'd1, 4'd0, 4'd1};
            b_tab = '{4'd0, 4'd0, 4'd1, 4'd1};
            for (int i = 0; i < 4; i++) begin
                check_val("s1_op_a", {4'd0, u_if1.op_a}, {4'd0, a_tab[i]});
                check_val("s1_op_b", {4'd0, u_if1.op_b}, {4'd0, b_tab[i]});
                check_val("s1_busy", {7'd0, u_if1.busy}, 8'h01);
                check_val("s1_sig", u_if1.sig, sig_exp(sig_tab[i]));
                tick();
                if (i == 0) begin
                    check_val("s0_done1", {7'd0, u_if0.done}, 8'h01);
                    check_val("s0_busy1", {7'd0, u_if0.busy}, 8'h00);
                end else begin
                    check_val("s0_quiet", {7'd0, u_if0.done}, 8'h00);
                end
            end
        end
        check_val("s1_done", {7'd0, u_if1.done}, 8'h01);
        check_val("s1_end_sig", u_if1.sig, sig_exp(8'h0f));
        tick();
        check_val("s1_done_off", {7'd0, u_if1.done}, 8'h00);
        check_val("s1_idle_a", {4'd0, u_if1.op_a}, 8'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_sigs_seq.md
BUS_SIGS_SEQ -- requirements
Module: bus_sigs_seq

Interface
REQ-001 The block SHALL provide parameter A_LAST, default 3, as the last op_a value of each row sweep (legal range 0..15).
REQ-002 The block SHALL provide parameter B_LAST, default 3, as the last op_b value of the sweep (legal range 0..15).
REQ-003 Port clk SHALL be an input, 1 bit: the single clock, rising-edge active.
REQ-004 Port rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit: request a new sweep, sampled in IDLE only.
REQ-006 Port step_en SHALL be an input, 1 bit: advance permission, where low holds the current step.
REQ-007 Port abort SHALL be an input, 1 bit: synchronous sweep cancel.
REQ-008 Port result SHALL be an input, 4 bits: combinational result returned by the downstream bus_sigs stage for the current operands.
REQ-009 Port op_a SHALL be an output, 4 bits: driven to downstream in_1.
REQ-010 Port op_b SHALL be an output, 4 bits: driven to downstream in_2.
REQ-011 Port sel SHALL be an output, 1 bit: driven to downstream in_3.
REQ-012 Port busy SHALL be an output, 1 bit: high while in RUN.
REQ-013 Port done SHALL be an output, 1 bit: one-cycle completion pulse.
REQ-014 Port sig SHALL be an output, 8 bits: result signature.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 SHALL cause a transition to RUN on the next edge, with op_a=0, op_b=0 and sig cleared to 8'h00 on that same edge.
REQ-017 In IDLE, op_a, op_b and sel SHALL be 0, and busy and done SHALL be 0.
REQ-018 sel SHALL be a registered value equal to (op_b != 0) in every cycle of RUN.
REQ-019 In RUN with step_en=1, each edge SHALL fold result into sig, then increment op_a.
REQ-020 When op_a==A_LAST, the step SHALL wrap op_a to 0 and increment op_b instead.
REQ-021 In RUN with step_en=0, op_a, op_b, sel and sig SHALL hold, so the held step is not counted.
REQ-022 In RUN with step_en=1, op_a==A_LAST and op_b==B_LAST, the block SHALL fold the final result and enter DONE; op_a and op_b SHALL hold their last values during DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1 and busy=0, then return to IDLE unconditionally.
REQ-024 A full sweep with step_en held high SHALL take (A_LAST+1)*(B_LAST+1) RUN cycles, with done asserted in the following cycle.
REQ-025 start SHALL be ignored in RUN and DONE, so no restart or queuing occurs.
REQ-026 abort=1 in RUN or DONE SHALL force IDLE on the next edge with no done pulse, clear the operands and hold sig.
REQ-027 abort SHALL have priority over step_en and over the final-step transition.
REQ-028 abort=1 in IDLE SHALL have no effect, and start SHALL be ignored in any cycle where abort=1.
REQ-029 With A_LAST=0 and B_LAST=0, the sweep SHALL take one RUN cycle.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, with op_a=0, op_b=0, sel=0, busy=0, done=0 and sig=8'h00, regardless of clk.
REQ-031 Reset asserted mid-sweep SHALL discard the sweep, and the block SHALL produce no done pulse afterwards.
REQ-032 After rst_n deasserts, the block SHALL remain in IDLE until start is sampled high.

Configuration
REQ-033 Macro BUS_SIGS_SEQ_SIG_EN SHALL control the signature logic.
REQ-034 With BUS_SIGS_SEQ_SIG_EN defined, each counted step SHALL update sig to {sig[6:0],sig[7]} XOR {4'h0,result}.
REQ-035 Without BUS_SIGS_SEQ_SIG_EN defined, no signature register SHALL exist, sig SHALL be tied to 8'h00 and result SHALL be unused.
REQ-036 All other behaviour SHALL be identical with and without BUS_SIGS_SEQ_SIG_EN.

Verification
REQ-037 Bench SHALL cover: defaults, step_en=1, start pulse -> (op_a,op_b) runs 0,0 / 1,0 / 2,0 / 3,0 / 0,1 ... 3,3 over 16 cycles; sel=0 for the first 4 cycles then 1; done high in cycle 17 only.
REQ-038 Bench SHALL cover: step_en low for 3 cycles at op_a=2,op_b=1 -> operands and sel hold for 3 cycles; total RUN length = 19 cycles.
REQ-039 Bench SHALL cover: A_LAST=1, B_LAST=1, result tied 4'h1, SIG_EN defined -> sig = 01, 03, 07, 0F; final sig=8'h0F with done; SIG_EN undefined -> sig=8'h00 throughout.
REQ-040 Bench SHALL cover: abort at op_a=1,op_b=2 -> IDLE next cycle, operands 0, done never asserted; start in the same cycle as abort -> ignored.
REQ-041 Bench SHALL cover: start pulses while busy=1 -> sequence unchanged, exactly one done pulse.
REQ-042 Bench SHALL cover: rst_n low between clock edges mid-sweep -> all outputs 0 immediately; start after release -> fresh sweep from 0,0.
